// File: rtl/mash_poly_predictor_if.sv
// Sample/prediction bundle for mash_poly_predictor: the master drives samples and
// control, the slave returns the registered prediction, its valid strobe and the saturation flag.
interface mash_poly_predictor_if #(
    parameter int W = 4
);
    logic                  flush;
    logic [1:0]            ord;
    logic                  in_valid;
    logic signed [W-1:0]   x;
    logic                  out_valid;
    logic signed [W+2:0]   y_out;
    logic                  sat;

    modport master (
        output flush, ord, in_valid, x,
        input  out_valid, y_out, sat
    );

    modport slave (
        input  flush, ord, in_valid, x,
        output out_valid, y_out, sat
    );
endinterface

// File: rtl/mash_poly_predictor.sv
// Runtime order 0..3 polynomial extrapolator for the MASH cancellation path.
// Define MASH_PRED_SAT_EN to clamp predictions to the W-bit signed range.
module mash_poly_predictor #(
    parameter int W = 4
) (
    input logic                  clck,
    input logic                  rst,
    mash_poly_predictor_if.slave bus
);
    localparam int YW = W + 3;

    logic signed [W-1:0]  h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
    logic [1:0]           ord_q, ord_d;
    logic [1:0]           fill_q, fill_d;
    logic signed [YW-1:0] y_q, y_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_q, sat_d;

    logic signed [YW-1:0] h1_e, h2_e, h3_e, p, y_c;
    logic                 sat_c;

    assign h1_e = {{3{h1_q[W-1]}}, h1_q};
    assign h2_e = {{3{h2_q[W-1]}}, h2_q};
    assign h3_e = {{3{h3_q[W-1]}}, h3_q};

    always_comb begin
        p = '0;
        unique case (ord_q)
            2'd0: p = '0;
            2'd1: p = h1_e;
            2'd2: p = (h1_e <<< 1) - h2_e;
            2'd3: p = (h1_e <<< 1) + h1_e - (h2_e <<< 1) - h2_e + h3_e;
            default: p = '0;
        endcase
    end

`ifdef MASH_PRED_SAT_EN
    localparam logic signed [YW-1:0] PMax = YW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [YW-1:0] PMin = -PMax - YW'(1);

    always_comb begin
        y_c   = p;
        sat_c = 1'b0;
        if (p > PMax) begin
            y_c   = PMax;
            sat_c = 1'b1;
        end else if (p < PMin) begin
            y_c   = PMin;
            sat_c = 1'b1;
        end
    end
`else
    assign y_c   = p;
    assign sat_c = 1'b0;
`endif

    always_comb begin
        h1_d        = h1_q;
        h2_d        = h2_q;
        h3_d        = h3_q;
        ord_d       = ord_q;
        fill_d      = fill_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        sat_d       = 1'b0;
        // Flush beats a coincident sample: the sample is dropped, y_out holds.
        if (bus.flush) begin
            h1_d   = '0;
            h2_d   = '0;
            h3_d   = '0;
            fill_d = '0;
            ord_d  = bus.ord;
        end else if (bus.in_valid) begin
            h3_d        = h2_q;
            h2_d        = h1_q;
            h1_d        = bus.x;
            y_d         = y_c;
            sat_d       = sat_c;
            out_valid_d = (fill_q >= ord_q);
            fill_d      = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        end
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            h1_q        <= '0;
            h2_q        <= '0;
            h3_q        <= '0;
            ord_q       <= 2'd2;
            fill_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            h3_q        <= h3_d;
            ord_q       <= ord_d;
            fill_q      <= fill_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.y_out     = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/mash_poly_predictor.md
# mash_poly_predictor

Parametrised polynomial-extrapolation stage for the MASH sigma-delta DAC noise-cancellation path. It generalises the fixed second-order part (y = 2·x[n-1] − x[n-2]) to a runtime-selectable order 0..3 and a configurable sample width. It adds a sample-valid strobe, a history-fill qualifier, a synchronous flush and optional output saturation. It sits between the MASH stage outputs and the cancellation-network summer.

## Interface
- `W`, default 4: signed input sample width; legal range ≥ 2.
- `clck` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous history clear and order capture.
- `ord` input 2: requested predictor order; captured only on `flush`.
- `in_valid` input 1: `x` carries a new sample this cycle.
- `x` input W: signed input sample.
- `out_valid` output 1: `y_out` holds a new qualified prediction; one-cycle pulse.
- `y_out` output W+3: signed prediction.
- `sat` output 1: saturation event flag, aligned with `out_valid`.

## Operation
- State:
  - History registers `h1`, `h2`, `h3` (W bits signed), holding x[n-1], x[n-2], x[n-3].
  - `ord_q` (2 bits).
  - Fill counter `fill` (0..3, saturating).
- On a cycle with `in_valid`=1 and `flush`=0:
  - Compute `p` from the history values before the shift:
    - `ord_q`=0: p = 0.
    - `ord_q`=1: p = h1.
    - `ord_q`=2: p = 2·h1 − h2.
    - `ord_q`=3: p = 3·h1 − 3·h2 + h3.
  - Arithmetic is sign-extended to W+3 bits. The worst case |p| ≤ 7·2^(W−1) fits, so there is no internal overflow.
  - Register `y_out` ← p.
  - Shift history: h3←h2, h2←h1, h1←x.
  - `out_valid` ← 1 iff `fill` ≥ `ord_q` (evaluated before the increment).
  - `fill` ← min(fill+1, 3).
- On a cycle with `in_valid`=0 and `flush`=0:
  - History, `fill` and `y_out` hold.
  - `out_valid` ← 0.
  - `sat` ← 0.
- On a cycle with `flush`=1, regardless of `in_valid`:
  - h1..h3 ← 0, `fill` ← 0, `ord_q` ← `ord`.
  - `out_valid` ← 0, `sat` ← 0; `y_out` holds.
  - A sample presented in the same cycle is discarded; flush wins.
- `ord` changes outside a flush cycle have no effect.
- Fill qualifier: the first qualified output follows the (`ord_q`+1)-th accepted sample after reset or flush. With `ord_q`=0, every accepted sample produces `out_valid`=1 with y_out=0.
- Unqualified accepted samples still update `y_out`, but `out_valid` stays 0.

## Timing
- Reset values:
  - `y_out`=0, `out_valid`=0, `sat`=0.
  - h1..h3=0, `fill`=0.
  - `ord_q`=2, the classic second-order mode.
- Reset is asynchronous assert; release takes effect at the next clock edge.
- Latency: a sample accepted at edge t contributes to the prediction emitted at edge t+1 of the *next* accepted sample. Each output is registered one edge after the `in_valid` cycle that triggers it.
- Throughput: one sample per clock; `in_valid` may be held high continuously.
- Reset asserted mid-stream clears everything immediately; no partial output is emitted.

## Configuration
- `MASH_PRED_SAT_EN` defined:
  - p is clamped to the W-bit signed range [−2^(W−1), 2^(W−1)−1] and sign-extended onto `y_out`.
  - `sat` is registered 1 when clamping occurred on a qualified or unqualified accepted sample; 0 otherwise.
- `MASH_PRED_SAT_EN` undefined:
  - `y_out` carries the full W+3-bit result.
  - `sat` is tied to 0.

## Test plan
- Reset, then W=4, `ord_q`=2 by default; feed x = 1, 2, 3, 7 on consecutive cycles:
  - `out_valid` is 0, 0 after the first two samples.
  - Then 1 with y_out=3 (2·2−1).
  - Then 1 with y_out=4 (2·3−2).
- Flush with `ord`=3; feed 7, −8, 7, 0 (no SAT_EN):
  - First three outputs are unqualified.
  - Fourth gives `out_valid`=1, y_out=52, `sat`=0.
- Same stimulus with `MASH_PRED_SAT_EN`: fourth output y_out=7, `sat`=1.
- Flush with `ord`=1; feed 5, then toggle `in_valid` 1/0 with x=−3:
  - Outputs 5 then −3, each a one-cycle `out_valid` pulse.
  - No pulse on idle cycles.
- Assert `flush` and `in_valid` together with x=6, then feed 2 in `ord`=1 mode:
  - The 6 is discarded.
  - The first output after 2 is unqualified.
- Assert `rst` mid-stream in `ord`=3 mode:
  - All outputs are 0 immediately.
  - `ord_q` returns to 2; a fresh stream needs 3 samples before `out_valid`.
